// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between NUM_CORES cores.
// One owner per tenure, optional hold limit, at least one idle cycle between tenures.
module rr_bus_arbiter #(
    parameter  int NUM_CORES = 2,
    parameter  int ADDR_W    = 9,
    parameter  int DATA_W    = 8,
    parameter  int MAX_HOLD  = 0,
    localparam int ID_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [NUM_CORES-1:0]        core_request_i,
    output logic [NUM_CORES-1:0]        core_grant_o,
    input  logic [NUM_CORES-1:0]        core_rw_i,
    input  logic [NUM_CORES*ADDR_W-1:0] core_address_i,
    input  logic [NUM_CORES*DATA_W-1:0] core_data_in_i,
    output logic [NUM_CORES*DATA_W-1:0] core_data_out_o,
    output logic [ADDR_W-1:0]           ram_address_o,
    output logic [DATA_W-1:0]           ram_data_in_o,
    input  logic [DATA_W-1:0]           ram_data_out_i,
    output logic                        ram_rw_o,
    output logic                        bus_busy_o,
    output logic [ID_W-1:0]             owner_id_o,
    output logic                        hold_timeout_o
);

    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [ID_W-1:0]  LAST_RST  = ID_W'(NUM_CORES - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        owner_q, owner_d;
    logic [ID_W-1:0]        last_q, last_d;
    logic [CNT_W-1:0]       hold_cnt_q, hold_cnt_d;
    logic [NUM_CORES-1:0]   grant_q, grant_d;

    logic                   pick_valid;
    logic [ID_W-1:0]        pick_id;
    logic [ID_W-1:0]        scan_id;
    logic                   owner_req;
    logic                   cut_by_hold;

    // Search starts just after the previous owner so every requester gets a turn.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        scan_id    = '0;
        for (int off = 1; off <= NUM_CORES; off++) begin
            if (int'(last_q) + off >= NUM_CORES) begin
                scan_id = ID_W'(int'(last_q) + off - NUM_CORES);
            end else begin
                scan_id = ID_W'(int'(last_q) + off);
            end
            if (!pick_valid && core_request_i[scan_id]) begin
                pick_valid = 1'b1;
                pick_id    = scan_id;
            end
        end
    end

    assign owner_req   = core_request_i[owner_q];
    assign cut_by_hold = (state_q == ST_BUSY) && (MAX_HOLD != 0) &&
                         (hold_cnt_q == HOLD_LAST) && owner_req;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        grant_d    = grant_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d    = ST_BUSY;
                    owner_d    = pick_id;
                    hold_cnt_d = '0;
                    grant_d    = NUM_CORES'(1) << pick_id;
                end
            end
            ST_BUSY: begin
                if (!owner_req || cut_by_hold) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    last_d  = owner_q;
                end else if ((MAX_HOLD != 0) && (hold_cnt_q != HOLD_LAST)) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            last_q     <= LAST_RST;
            hold_cnt_q <= '0;
            grant_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
            grant_q    <= grant_d;
        end
    end

    assign core_grant_o   = grant_q;
    assign bus_busy_o     = (state_q == ST_BUSY);
    assign owner_id_o     = owner_q;
    assign hold_timeout_o = cut_by_hold;

    // Idle bus drives zeros so memory never sees a stray write.
    always_comb begin
        ram_address_o   = '0;
        ram_data_in_o   = '0;
        ram_rw_o        = 1'b0;
        core_data_out_o = '0;
        if (state_q == ST_BUSY) begin
            ram_address_o = core_address_i[owner_q*ADDR_W +: ADDR_W];
            ram_data_in_o = core_data_in_i[owner_q*DATA_W +: DATA_W];
            ram_rw_o      = core_rw_i[owner_q];
            core_data_out_o[owner_q*DATA_W +: DATA_W] = ram_data_out_i;
        end
    end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Bench for rr_bus_arbiter: a hold-limited (3) and an unlimited instance share stimulus,
// each checked every cycle against a tenure-level model plus literal expectations.
module tb_rr_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  rw;
    logic [35:0] addr;
    logic [31:0] wdata;
    logic [7:0]  ram_dout;

    logic [3:0]  dut_grant [2];
    logic        dut_busy  [2];
    logic [1:0]  dut_owner [2];
    logic        dut_to    [2];
    logic [8:0]  dut_raddr [2];
    logic [7:0]  dut_rwd   [2];
    logic        dut_rrw   [2];
    logic [31:0] dut_dout  [2];

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    rr_bus_arbiter #(.NUM_CORES(4), .ADDR_W(9), .DATA_W(8), .MAX_HOLD(3)) u_hold (
        .clk_i(clk), .reset_i(reset), .core_request_i(req), .core_grant_o(dut_grant[0]),
        .core_rw_i(rw), .core_address_i(addr), .core_data_in_i(wdata),
        .core_data_out_o(dut_dout[0]), .ram_address_o(dut_raddr[0]), .ram_data_in_o(dut_rwd[0]),
        .ram_data_out_i(ram_dout), .ram_rw_o(dut_rrw[0]), .bus_busy_o(dut_busy[0]),
        .owner_id_o(dut_owner[0]), .hold_timeout_o(dut_to[0]));

    rr_bus_arbiter #(.NUM_CORES(4), .ADDR_W(9), .DATA_W(8), .MAX_HOLD(0)) u_unl (
        .clk_i(clk), .reset_i(reset), .core_request_i(req), .core_grant_o(dut_grant[1]),
        .core_rw_i(rw), .core_address_i(addr), .core_data_in_i(wdata),
        .core_data_out_o(dut_dout[1]), .ram_address_o(dut_raddr[1]), .ram_data_in_o(dut_rwd[1]),
        .ram_data_out_i(ram_dout), .ram_rw_o(dut_rrw[1]), .bus_busy_o(dut_busy[1]),
        .owner_id_o(dut_owner[1]), .hold_timeout_o(dut_to[1]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Tenure-level model: who holds the bus, for how many cycles, and who went last.
    int  hold_lim [2] = '{3, 0};
    bit  m_busy   [2];
    int  m_owner  [2];
    int  m_last   [2];
    int  m_age    [2];
    bit  model_valid = 1'b0;

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (reset) begin
                m_busy[m]  = 1'b0;
                m_owner[m] = 0;
                m_last[m]  = 3;
                m_age[m]   = 0;
            end else if (!m_busy[m]) begin
                for (int k = 1; k <= 4; k++) begin
                    if (!m_busy[m] && req[(m_last[m] + k) % 4]) begin
                        m_busy[m]  = 1'b1;
                        m_owner[m] = (m_last[m] + k) % 4;
                        m_age[m]   = 1;
                    end
                end
            end else if (!req[m_owner[m]] || (hold_lim[m] != 0 && m_age[m] == hold_lim[m])) begin
                m_busy[m] = 1'b0;
                m_last[m] = m_owner[m];
            end else begin
                m_age[m] = m_age[m] + 1;
            end
        end
        if (reset) model_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            for (int m = 0; m < 2; m++) begin
                logic [3:0]  e_grant;
                logic        e_to;
                logic [8:0]  e_addr;
                logic [7:0]  e_wd;
                logic        e_rw;
                logic [31:0] e_dout;
                e_grant = m_busy[m] ? (4'b0001 << m_owner[m]) : 4'b0000;
                e_to    = m_busy[m] && hold_lim[m] != 0 && m_age[m] == hold_lim[m] && req[m_owner[m]];
                e_addr  = m_busy[m] ? addr[m_owner[m]*9 +: 9] : 9'h000;
                e_wd    = m_busy[m] ? wdata[m_owner[m]*8 +: 8] : 8'h00;
                e_rw    = m_busy[m] ? rw[m_owner[m]] : 1'b0;
                e_dout  = m_busy[m] ? (32'(ram_dout) << (m_owner[m]*8)) : 32'h0;
                chk($sformatf("model grant i%0d", m), dut_grant[m], e_grant);
                chk($sformatf("model busy i%0d", m), dut_busy[m], m_busy[m]);
                chk($sformatf("model timeout i%0d", m), dut_to[m], e_to);
                chk($sformatf("model ram_addr i%0d", m), dut_raddr[m], e_addr);
                chk($sformatf("model ram_wdata i%0d", m), dut_rwd[m], e_wd);
                chk($sformatf("model ram_rw i%0d", m), dut_rrw[m], e_rw);
                chk($sformatf("model data_out i%0d", m), dut_dout[m], e_dout);
                if (m_busy[m]) chk($sformatf("model owner i%0d", m), dut_owner[m], m_owner[m]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0000;
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_both_grant(input string name, input logic [3:0] exp);
        chk({name, " i0"}, dut_grant[0], exp);
        chk({name, " i1"}, dut_grant[1], exp);
    endtask

    logic [3:0] t2_grant [20];
    logic       t2_to    [20];

    initial begin
        reset    = 1'b1;
        req      = 4'b0000;
        rw       = 4'b0000;
        addr     = {9'h133, 9'h055, 9'h0A2, 9'h011};
        wdata    = 32'h8877_665A;
        ram_dout = 8'h00;
        for (int i = 0; i < 20; i++) begin
            t2_grant[i] = (i % 4 == 3) ? 4'b0000 : (4'b0001 << ((i / 4) % 4));
            t2_to[i]    = (i % 4 == 2);
        end

        tick();
        tick();
        look();
        for (int m = 0; m < 2; m++) begin
            chk("reset grant", dut_grant[m], 4'b0000);
            chk("reset busy", dut_busy[m], 1'b0);
            chk("reset owner", dut_owner[m], 2'd0);
            chk("reset timeout", dut_to[m], 1'b0);
            chk("reset ram_rw", dut_rrw[m], 1'b0);
        end
        tick();
        reset = 1'b0;

        // T1: lone core 2
        req = 4'b0100;
        look();
        chk_both_grant("t1 pre grant", 4'b0000);
        tick();
        look();
        chk_both_grant("t1 grant", 4'b0100);
        chk("t1 owner", dut_owner[0], 2'd2);
        chk("t1 ram_addr", dut_raddr[0], 9'h055);
        tick();
        req = 4'b0000;
        look();
        chk_both_grant("t1 hold grant", 4'b0100);
        tick();
        look();
        chk_both_grant("t1 release grant", 4'b0000);
        chk("t1 release busy", dut_busy[1], 1'b0);

        // T2: all four requesting, hold limit 3 on instance 0
        tick();
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            tick();
            look();
            chk($sformatf("t2 grant c%0d", i), dut_grant[0], t2_grant[i]);
            chk($sformatf("t2 timeout c%0d", i), dut_to[0], t2_to[i]);
            chk($sformatf("t2 unl grant c%0d", i), dut_grant[1], 4'b0001);
        end

        // T3: core1 holds 50 cycles on the unlimited instance while core0 waits
        tick();
        do_reset();
        req = 4'b0010;
        tick();
        look();
        chk("t3 grant", dut_grant[1], 4'b0010);
        tick();
        req = 4'b0011;
        for (int i = 0; i < 50; i++) begin
            look();
            chk("t3 hold grant", dut_grant[1], 4'b0010);
            chk("t3 no timeout", dut_to[1], 1'b0);
            tick();
        end
        req = 4'b0001;
        look();
        chk("t3 drop grant", dut_grant[1], 4'b0010);
        tick();
        look();
        chk("t3 gap grant", dut_grant[1], 4'b0000);
        tick();
        look();
        chk("t3 core0 grant", dut_grant[1], 4'b0001);

        // T4: core3 writes A5 to 1F0; other cores present conflicting write data
        tick();
        do_reset();
        addr  = {9'h1F0, 9'h055, 9'h0A2, 9'h011};
        wdata = 32'hA577_665A;
        rw    = 4'b1111;
        req   = 4'b1000;
        look();
        for (int m = 0; m < 2; m++) begin
            chk("t4 idle ram_rw", dut_rrw[m], 1'b0);
            chk("t4 idle ram_addr", dut_raddr[m], 9'h000);
            chk("t4 idle ram_wdata", dut_rwd[m], 8'h00);
        end
        tick();
        look();
        for (int m = 0; m < 2; m++) begin
            chk("t4 ram_rw", dut_rrw[m], 1'b1);
            chk("t4 ram_wdata", dut_rwd[m], 8'hA5);
            chk("t4 ram_addr", dut_raddr[m], 9'h1F0);
        end

        // T5: core3 reads 3C, then core1 takes over
        tick();
        rw       = 4'b0000;
        ram_dout = 8'h3C;
        look();
        for (int m = 0; m < 2; m++) begin
            chk("t5 data_out", dut_dout[m], 32'h3C00_0000);
            chk("t5 ram_rw", dut_rrw[m], 1'b0);
        end
        tick();
        req = 4'b0010;
        look();
        chk_both_grant("t5 still core3", 4'b1000);
        tick();
        look();
        chk("t5 idle data_out", dut_dout[0], 32'h0);
        chk("t5 idle data_out u", dut_dout[1], 32'h0);
        tick();
        look();
        chk_both_grant("t5 core1 grant", 4'b0010);
        chk("t5 core1 data_out", dut_dout[1], 32'h0000_3C00);

        // T6: reset during core2 tenure with everyone requesting
        tick();
        do_reset();
        req = 4'b0100;
        tick();
        look();
        chk_both_grant("t6 grant", 4'b0100);
        tick();
        req = 4'b1111;
        look();
        chk_both_grant("t6 no preempt", 4'b0100);
        tick();
        reset = 1'b1;
        rw    = 4'b1111;
        tick();
        reset = 1'b0;
        look();
        for (int m = 0; m < 2; m++) begin
            chk("t6 reset grant", dut_grant[m], 4'b0000);
            chk("t6 reset busy", dut_busy[m], 1'b0);
            chk("t6 reset ram_rw", dut_rrw[m], 1'b0);
        end
        tick();
        look();
        chk_both_grant("t6 core0 next", 4'b0001);

        // Sole requester is re-granted after each cut; model checks every cycle
        tick();
        req = 4'b0001;
        repeat (12) tick();
        look();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
